mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 156 +++++++++++++++
 tb/tb_mem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_responder : word memory behind read/write valid-ready channels         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_responder #(
  parameter int BUS_WIDTH    = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 raddr_valid,
  output logic                 raddr_ready,
  input  logic [BUS_WIDTH-1:0] raddr,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [BUS_WIDTH-1:0] rdata,
  input  logic                 waddr_valid,
  output logic                 waddr_ready,
  input  logic [BUS_WIDTH-1:0] waddr,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [BUS_WIDTH-1:0] wdata
);
  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AW-1:0]        rword_q, rword_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                 waddr_held_q, waddr_held_d;
  logic                 wdata_held_q, wdata_held_d;
  logic [AW-1:0]        wword_q, wword_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [BUS_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] raddr_word, waddr_word, cap_word;
  logic          capture, mem_we, raddr_fire, waddr_fire, wdata_fire;
  logic          unused_lo;

  // Only the word index is used; byte offset and upper bits are dropped so addresses wrap.
  assign raddr_word = raddr[AW+1:2];
  assign waddr_word = waddr[AW+1:2];
  assign unused_lo  = ^{raddr[1:0], waddr[1:0]};

  generate
    if (BUS_WIDTH > AW + 2) begin : g_addr_hi
      logic unused_hi;
      assign unused_hi = ^{raddr[BUS_WIDTH-1:AW+2], waddr[BUS_WIDTH-1:AW+2]};
    end
  endgenerate

  assign raddr_ready = (state_q == R_IDLE) && !rst;
  assign rdata_valid = (state_q == R_RESP) && !rst;
  assign rdata       = rst ? '0 : rdata_q;
  assign waddr_ready = !waddr_held_q && !rst;
  assign wdata_ready = !wdata_held_q && !rst;

  assign raddr_fire = raddr_valid && raddr_ready;
  assign waddr_fire = waddr_valid && waddr_ready;
  assign wdata_fire = wdata_valid && wdata_ready;
  assign mem_we     = waddr_held_q && wdata_held_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rword_d  = rword_q;
    rdata_d  = rdata_q;
    capture  = 1'b0;
    cap_word = rword_q;
    case (state_q)
      R_IDLE: begin
        if (raddr_fire) begin
          rword_d = raddr_word;
          if (READ_LATENCY == 1) begin
            state_d  = R_RESP;
            capture  = 1'b1;
            cap_word = raddr_word;
          end else begin
            state_d = R_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      R_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = R_RESP;
          capture = 1'b1;
        end
      end
      R_RESP: begin
        if (rdata_ready) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
    // Write-first: a commit landing on the capture edge for the same word wins.
    if (capture) begin
      rdata_d = (mem_we && (wword_q == cap_word)) ? wdata_q : mem_q[cap_word];
    end
  end

  always_comb begin
    waddr_held_d = waddr_held_q;
    wdata_held_d = wdata_held_q;
    wword_d      = wword_q;
    wdata_d      = wdata_q;
    if (mem_we) begin
      waddr_held_d = 1'b0;
      wdata_held_d = 1'b0;
    end
    if (waddr_fire) begin
      waddr_held_d = 1'b1;
      wword_d      = waddr_word;
    end
    if (wdata_fire) begin
      wdata_held_d = 1'b1;
      wdata_d      = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= R_IDLE;
      cnt_q        <= 4'd0;
      rword_q      <= '0;
      rdata_q      <= '0;
      waddr_held_q <= 1'b0;
      wdata_held_q <= 1'b0;
      wword_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rword_q      <= rword_d;
      rdata_q      <= rdata_d;
      waddr_held_q <= waddr_held_d;
      wdata_held_q <= wdata_held_d;
      wword_q      <= wword_d;
      wdata_q      <= wdata_d;
    end
  end

  // Storage is never reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[wword_q] <= wdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_responder : scoreboard bench, latency-1 and latency-4 instances     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mem_responder;
  localparam int BW    = 32;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          raddr_valid = 1'b0, rdata_ready = 1'b0;
  logic          waddr_valid = 1'b0, wdata_valid = 1'b0;
  logic [BW-1:0] raddr = '0, waddr = '0, wdata = '0;

  logic          raddr_ready1, rdata_valid1, waddr_ready1, wdata_ready1;
  logic          raddr_ready4, rdata_valid4, waddr_ready4, wdata_ready4;
  logic [BW-1:0] rdata1, rdata4;

  int            checks = 0;
  int            errors = 0;
  logic [BW-1:0] q1[$];
  logic [BW-1:0] q4[$];

  always #5 clk = ~clk;

  mem_responder #(.BUS_WIDTH(BW), .DEPTH(DEPTH), .READ_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .raddr_valid(raddr_valid), .raddr_ready(raddr_ready1), .raddr(raddr),
    .rdata_valid(rdata_valid1), .rdata_ready(rdata_ready), .rdata(rdata1),
    .waddr_valid(waddr_valid), .waddr_ready(waddr_ready1), .waddr(waddr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready1), .wdata(wdata)
  );

  mem_responder #(.BUS_WIDTH(BW), .DEPTH(DEPTH), .READ_LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst(rst),
    .raddr_valid(raddr_valid), .raddr_ready(raddr_ready4), .raddr(raddr),
    .rdata_valid(rdata_valid4), .rdata_ready(rdata_ready), .rdata(rdata4),
    .waddr_valid(waddr_valid), .waddr_ready(waddr_ready4), .waddr(waddr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready4), .wdata(wdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitors: pop on every rdata transfer.
  always @(negedge clk) begin
    if (!rst && rdata_ready && rdata_valid1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb1_unexpected: got %h expected no response", rdata1);
      end else chk("sb1_rdata", rdata1, q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && rdata_ready && rdata_valid4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb4_unexpected: got %h expected no response", rdata4);
      end else chk("sb4_rdata", rdata4, q4.pop_front());
    end
  end

  task automatic drive_wr(input logic [31:0] wa, input logic [31:0] wd);
    waddr_valid = 1'b1; waddr = wa;
    wdata_valid = 1'b1; wdata = wd;
  endtask

  task automatic stop_wr();
    waddr_valid = 1'b0;
    wdata_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] wa, input logic [31:0] wd);
    @(posedge clk); #1;
    drive_wr(wa, wd);
    @(negedge clk);
    chk("wr_waddr_ready1", 32'(waddr_ready1), 1);
    chk("wr_wdata_ready4", 32'(wdata_ready4), 1);
    @(posedge clk); #1;
    stop_wr();
    @(negedge clk);
    chk("wr_pending_waddr_ready1", 32'(waddr_ready1), 0);
    chk("wr_pending_wdata_ready4", 32'(wdata_ready4), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_done_wdata_ready1", 32'(wdata_ready1), 1);
    chk("wr_done_waddr_ready4", 32'(waddr_ready4), 1);
  endtask

  // Read with rdata_ready low for 5 cycles. wk=-1 writes in the cycle before the
  // read address; wk=k>0 writes in the k-th cycle after acceptance; wk=0 no write.
  task automatic do_read(input logic [31:0] a, input logic [31:0] e1, input logic [31:0] e4,
                         input int wk, input logic [31:0] wa, input logic [31:0] wd);
    @(posedge clk); #1;
    if (wk == -1) begin
      drive_wr(wa, wd);
      @(posedge clk); #1;
      stop_wr();
    end
    q1.push_back(e1);
    q4.push_back(e4);
    raddr_valid = 1'b1; raddr = a;
    @(negedge clk);
    chk("rd_raddr_ready1", 32'(raddr_ready1), 1);
    chk("rd_raddr_ready4", 32'(raddr_ready4), 1);
    @(posedge clk); #1;
    raddr_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (wk == k) drive_wr(wa, wd);
      @(negedge clk);
      chk("rd_rvalid1", 32'(rdata_valid1), 1);
      chk("rd_rvalid4", 32'(rdata_valid4), (k >= 4) ? 1 : 0);
      chk("rd_busy_raddr_ready1", 32'(raddr_ready1), 0);
      chk("rd_busy_raddr_ready4", 32'(raddr_ready4), 0);
      if (k == 1 || k == 5) chk("rd_hold_rdata1", rdata1, e1);
      if (k >= 4) chk("rd_hold_rdata4", rdata4, e4);
      @(posedge clk); #1;
      if (wk == k) stop_wr();
    end
    rdata_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rdata_ready = 1'b0;
    @(negedge clk);
    chk("rd_after_rvalid1", 32'(rdata_valid1), 0);
    chk("rd_after_rvalid4", 32'(rdata_valid4), 0);
    chk("rd_after_raddr_ready1", 32'(raddr_ready1), 1);
    chk("rd_after_raddr_ready4", 32'(raddr_ready4), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_raddr_ready1", 32'(raddr_ready1), 0);
    chk("rst_waddr_ready4", 32'(waddr_ready4), 0);
    chk("rst_wdata_ready1", 32'(wdata_ready1), 0);
    chk("rst_rvalid4", 32'(rdata_valid4), 0);
    chk("rst_rdata1", rdata1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_raddr_ready1", 32'(raddr_ready1), 1);
    chk("rel_waddr_ready4", 32'(waddr_ready4), 1);
    chk("rel_wdata_ready1", 32'(wdata_ready1), 1);

    // Same-cycle write then read
    do_write(32'h100, 32'hDEADBEEF);
    do_read(32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);

    // wdata three cycles ahead of waddr
    @(posedge clk); #1;
    wdata_valid = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    chk("early_wdata_ready1", 32'(wdata_ready1), 1);
    @(posedge clk); #1;
    wdata_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin waddr_valid = 1'b1; waddr = 32'h8; end
      @(negedge clk);
      chk("held_wdata_ready1", 32'(wdata_ready1), 0);
      chk("held_wdata_ready4", 32'(wdata_ready4), 0);
      chk("held_waddr_ready1", 32'(waddr_ready1), 1);
      @(posedge clk); #1;
      if (k == 3) waddr_valid = 1'b0;
    end
    @(negedge clk);
    chk("commit_waddr_ready1", 32'(waddr_ready1), 0);
    chk("commit_wdata_ready1", 32'(wdata_ready1), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_commit_waddr_ready1", 32'(waddr_ready1), 1);
    chk("post_commit_wdata_ready4", 32'(wdata_ready4), 1);
    do_read(32'h8, 32'h12345678, 32'h12345678, 0, 0, 0);

    // Write-first bypass on word 0x20
    do_write(32'h20, 32'h0);
    do_read(32'h20, 32'hA5A5A5A5, 32'hA5A5A5A5, -1, 32'h20, 32'hA5A5A5A5);
    do_read(32'h20, 32'hA5A5A5A5, 32'h5A5A5A5A, 2, 32'h20, 32'h5A5A5A5A);

    // Address aliasing
    do_write(32'h4, 32'h11111111);
    do_write(32'h4 + 32'(4 * DEPTH), 32'h22222222);
    do_read(32'h4, 32'h22222222, 32'h22222222, 0, 0, 0);
    do_read(32'h1007, 32'h22222222, 32'h22222222, 0, 0, 0);

    // Reset during R_WAIT with only waddr held
    do_write(32'h30, 32'hCAFEF00D);
    @(posedge clk); #1;
    raddr_valid = 1'b1; raddr = 32'h30;
    waddr_valid = 1'b1; waddr = 32'h30;
    @(posedge clk); #1;
    raddr_valid = 1'b0; waddr_valid = 1'b0;
    @(negedge clk);
    chk("mid_waddr_ready1", 32'(waddr_ready1), 0);
    chk("mid_raddr_ready4", 32'(raddr_ready4), 0);
    chk("mid_rvalid4", 32'(rdata_valid4), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    wdata_valid = 1'b1; wdata = 32'hBADBAD00;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("mrst_raddr_ready4", 32'(raddr_ready4), 0);
      chk("mrst_waddr_ready1", 32'(waddr_ready1), 0);
      chk("mrst_wdata_ready4", 32'(wdata_ready4), 0);
      chk("mrst_rvalid1", 32'(rdata_valid1), 0);
      chk("mrst_rdata1", rdata1, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    wdata_valid = 1'b0;
    @(negedge clk);
    chk("mrel_raddr_ready4", 32'(raddr_ready4), 1);
    chk("mrel_waddr_ready4", 32'(waddr_ready4), 1);
    chk("mrel_wdata_ready1", 32'(wdata_ready1), 1);
    for (int k = 0; k < 5; k++) begin
      chk("mrel_rvalid4", 32'(rdata_valid4), 0);
      chk("mrel_rvalid1", 32'(rdata_valid1), 0);
      @(negedge clk);
    end
    do_read(32'h30, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 0);

    repeat (3) @(posedge clk);
    chk("sb1_drained", 32'(q1.size()), 0);
    chk("sb4_drained", 32'(q4.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
